dcmi_frame_dma: RTL
===================

DCMI_FRAME_DMA -- requirements
Module: dcmi_frame_dma

Interface
REQ-001 Parameters: DCMI_BASE (default 32'h0000_0000) is the DCMI slave base; DCMI_BASE+0x000 is the pixel FIFO and DCMI_BASE+0x004 is the control register.
REQ-002 Parameter LINE_PIXELS (default 320): pixels transferred per line.
REQ-003 Clocking and reset: single clock HCLK; reset HRESETn is asynchronous, active-low.
REQ-004 HCLK  in  1  system clock; all logic rising-edge.
REQ-005 HRESETn  in  1  async active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a frame capture, accepted only in IDLE.
REQ-007 abort  in  1  level; forces termination of the current capture.
REQ-008 buf_base  in  32  frame-buffer byte address, halfword-aligned; sampled on an accepted start.
REQ-009 num_lines  in  9  lines per frame, 1..511; sampled on an accepted start; 0 is treated as 1.
REQ-010 dcmi_int  in  1  DCMI line-ready interrupt, level.
REQ-011 M_HADDR  out  32  AHB-Lite master address.
REQ-012 M_HTRANS  out  2  AHB-Lite master transfer type; only IDLE (2'b00) and NONSEQ (2'b10) are used.
REQ-013 M_HWRITE  out  1  AHB-Lite master write flag.
REQ-014 M_HSIZE  out  3  AHB-Lite master transfer size.
REQ-015 M_HWDATA  out  32  AHB-Lite master write data.
REQ-016 M_HRDATA  in  32  AHB-Lite master read data.
REQ-017 M_HREADY  in  1  AHB-Lite master ready.
REQ-018 M_HRESP  in  1  AHB-Lite master response; 1 = ERROR.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle pulse when a frame completes.
REQ-021 err  out  1  sticky bus-error flag; cleared by an accepted start.
REQ-022 line_cnt  out  9  number of lines completed in the current frame.

Function
REQ-023 The FSM shall have exactly these states: IDLE, ARM_A, ARM_D, WAIT_LINE, RD_A, RD_D, WR_A, WR_D, CLR_A, CLR_D, DIS_A, DIS_D.
REQ-024 Address phase (states *_A): drive M_HTRANS=NONSEQ with the state's M_HADDR/M_HWRITE/M_HSIZE; advance to the paired *_D state only on a cycle with M_HREADY=1; otherwise hold all address-phase outputs stable.
REQ-025 Data phase (states *_D): drive M_HTRANS=IDLE; the phase completes on the first cycle with M_HREADY=1.
REQ-026 M_HTRANS shall be IDLE in IDLE and WAIT_LINE; the block keeps at most one transfer outstanding.
REQ-027 Accepted start: latch buf_base and num_lines into registers, clear err, clear line_cnt, clear the pixel counter, set the write pointer to buf_base, go to ARM_A.
REQ-028 ARM: word write of 32'h0000_000A to DCMI_BASE+0x004 (dcmi_en=1, int_en=1); then go to WAIT_LINE.
REQ-029 WAIT_LINE: go to RD_A when dcmi_int=1.
REQ-030 RD: word read of DCMI_BASE+0x000; capture M_HRDATA[11:0] into the pixel register at data-phase completion; then go to WR_A.
REQ-031 WR: halfword write (M_HSIZE=3'b001) to the write pointer with M_HWDATA={20'b0, pixel}; M_HWDATA shall be driven during WR_D.
REQ-032 At WR_D completion: write pointer += 2 (32-bit, wraps modulo 2^32) and pixel counter += 1.
REQ-033 At WR_D completion, if the pixel counter reaches LINE_PIXELS: go to CLR_A, clear the pixel counter, increment line_cnt; otherwise go to RD_A.
REQ-034 CLR: word write of 32'h0000_000B to DCMI_BASE+0x004 (int_clr plus enables).
REQ-035 After CLR: if line_cnt equals the latched num_lines, go to DIS_A; otherwise go to WAIT_LINE.
REQ-036 DIS: word write of 32'h0 to DCMI_BASE+0x004; after DIS_D go to IDLE and pulse done for exactly one cycle, except when the DIS sequence was entered through abort or error (no done pulse then).
REQ-037 abort=1 in any state other than IDLE/DIS_*: at the next phase boundary go to DIS_A; an in-flight data phase shall complete first, and WAIT_LINE exits immediately.
REQ-038 M_HRESP=1 in any *_D state: set err, go to DIS_A; if the error occurs in DIS_D itself, go directly to IDLE.
REQ-039 start while busy shall be ignored; dcmi_int is ignored outside WAIT_LINE.
REQ-040 If abort and dcmi_int occur in the same cycle in WAIT_LINE, abort wins.

Reset
REQ-041 HRESETn=0 shall asynchronously force: state=IDLE, M_HTRANS=IDLE, M_HADDR=0, M_HWRITE=0, M_HSIZE=3'b010, M_HWDATA=0, busy=0, done=0, err=0, line_cnt=0, and clear all internal counters and registers.
REQ-042 Reset asserted mid-transfer shall abandon that transfer; no DCMI disable write is issued.

Verification
REQ-043 Single line: LINE_PIXELS=4, num_lines=1, buf_base=0x2000_0000, dcmi_int high, zero-wait slaves, FIFO returns 0x123,0x456,0x789,0xABC -> observed bus sequence is write 0xA to 0x004, then 4x(read 0x000, halfword write to 0x2000_0000/02/04/06 of those pixels), then write 0xB, then write 0x0; done pulses once; line_cnt=1.
REQ-044 Wait states: M_HREADY low for 3 cycles in RD_A and in WR_D -> address-phase outputs and M_HWDATA held stable throughout; data identical to REQ-043.
REQ-045 Multi-line: num_lines=3, dcmi_int pulsed per line -> three CLR writes; WAIT_LINE entered between lines; line_cnt steps 1,2,3; final write pointer = base+6*LINE_PIXELS.
REQ-046 Bus error: M_HRESP=1 in the second WR_D -> err=1, DIS write issued, IDLE, no done pulse; the next start clears err.
REQ-047 Abort in WAIT_LINE and abort during RD_D -> RD_D completes, then DIS write, then IDLE; no done pulse.
REQ-048 Async reset during WR_A -> all outputs reach reset values immediately, busy=0.

Source files
------------

// File: rtl/dcmi_frame_dma.sv
// DCMI frame capture DMA: arms the DCMI slave, moves LINE_PIXELS 12-bit pixels
// per line from the DCMI FIFO into a halfword frame buffer over AHB-Lite,
// acknowledges each line interrupt and disables the DCMI at frame end.
module dcmi_frame_dma #(
    parameter logic [31:0] DCMI_BASE   = 32'h0000_0000,
    parameter int unsigned LINE_PIXELS = 320
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] buf_base,
    input  logic [8:0]  num_lines,
    input  logic        dcmi_int,
    output logic [31:0] M_HADDR,
    output logic [1:0]  M_HTRANS,
    output logic        M_HWRITE,
    output logic [2:0]  M_HSIZE,
    output logic [31:0] M_HWDATA,
    input  logic [31:0] M_HRDATA,
    input  logic        M_HREADY,
    input  logic        M_HRESP,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [8:0]  line_cnt
);
    localparam int unsigned     PW        = $clog2(LINE_PIXELS + 1);
    localparam logic [PW-1:0]   PIX_LAST  = PW'(LINE_PIXELS - 1);
    localparam logic [31:0]     FIFO_ADDR = DCMI_BASE;
    localparam logic [31:0]     CTRL_ADDR = DCMI_BASE + 32'h4;
    localparam logic [1:0]      TR_IDLE   = 2'b00;
    localparam logic [1:0]      TR_NONSEQ = 2'b10;
    localparam logic [2:0]      SZ_HALF   = 3'b001;
    localparam logic [2:0]      SZ_WORD   = 3'b010;

    typedef enum logic [3:0] {
        IDLE, ARM_A, ARM_D, WAIT_LINE, RD_A, RD_D,
        WR_A, WR_D, CLR_A, CLR_D, DIS_A, DIS_D
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     wptr_q, wptr_d;
    logic [8:0]      nl_q, nl_d;
    logic [8:0]      line_q, line_d;
    logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [11:0]     pixel_q, pixel_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            quiet_q, quiet_d;   // DIS entered via abort/error: no done pulse
    logic            is_data;
    logic            unused_hrdata;

    assign unused_hrdata = ^M_HRDATA[31:12];
    assign is_data = (state_q == ARM_D) || (state_q == RD_D) || (state_q == WR_D) ||
                     (state_q == CLR_D) || (state_q == DIS_D);

    // State and datapath registers; reset abandons any transfer in flight
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            nl_q      <= '0;
            line_q    <= '0;
            pix_cnt_q <= '0;
            pixel_q   <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            quiet_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            nl_q      <= nl_d;
            line_q    <= line_d;
            pix_cnt_q <= pix_cnt_d;
            pixel_q   <= pixel_d;
            err_q     <= err_d;
            done_q    <= done_d;
            quiet_q   <= quiet_d;
        end
    end

    // Next-state: phase sequencing, line/pixel bookkeeping, abort and error exits
    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        nl_d      = nl_q;
        line_d    = line_q;
        pix_cnt_d = pix_cnt_q;
        pixel_d   = pixel_q;
        err_d     = err_q;
        done_d    = 1'b0;
        quiet_d   = quiet_q;
        if (is_data && M_HRESP) begin
            err_d   = 1'b1;
            quiet_d = 1'b1;
            state_d = (state_q == DIS_D) ? IDLE : DIS_A;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    wptr_d    = buf_base;
                    nl_d      = (num_lines == 9'd0) ? 9'd1 : num_lines;
                    line_d    = '0;
                    pix_cnt_d = '0;
                    err_d     = 1'b0;
                    quiet_d   = 1'b0;
                    state_d   = ARM_A;
                end
                ARM_A: if (M_HREADY) state_d = ARM_D;
                ARM_D: if (M_HREADY) state_d = WAIT_LINE;
                WAIT_LINE: begin
                    if (abort) begin
                        quiet_d = 1'b1;
                        state_d = DIS_A;
                    end else if (dcmi_int) begin
                        state_d = RD_A;
                    end
                end
                RD_A: if (M_HREADY) state_d = RD_D;
                RD_D: if (M_HREADY) begin
                    pixel_d = M_HRDATA[11:0];
                    state_d = WR_A;
                end
                WR_A: if (M_HREADY) state_d = WR_D;
                WR_D: if (M_HREADY) begin
                    wptr_d = wptr_q + 32'd2;
                    if (pix_cnt_q == PIX_LAST) begin
                        pix_cnt_d = '0;
                        line_d    = line_q + 9'd1;
                        state_d   = CLR_A;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        state_d   = RD_A;
                    end
                end
                CLR_A: if (M_HREADY) state_d = CLR_D;
                CLR_D: if (M_HREADY) state_d = (line_q == nl_q) ? DIS_A : WAIT_LINE;
                DIS_A: if (M_HREADY) state_d = DIS_D;
                DIS_D: if (M_HREADY) begin
                    done_d  = !quiet_q;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            // Abort takes effect only once the current data phase has finished
            if (is_data && M_HREADY && abort && state_q != DIS_D) begin
                quiet_d = 1'b1;
                state_d = DIS_A;
            end
        end
    end

    // Bus outputs decoded from state: NONSEQ in *_A, write data in *_D
    always_comb begin
        M_HTRANS = TR_IDLE;
        M_HADDR  = '0;
        M_HWRITE = 1'b0;
        M_HSIZE  = SZ_WORD;
        M_HWDATA = '0;
        case (state_q)
            ARM_A, CLR_A, DIS_A: begin
                M_HTRANS = TR_NONSEQ;
                M_HADDR  = CTRL_ADDR;
                M_HWRITE = 1'b1;
            end
            RD_A: begin
                M_HTRANS = TR_NONSEQ;
                M_HADDR  = FIFO_ADDR;
            end
            WR_A: begin
                M_HTRANS = TR_NONSEQ;
                M_HADDR  = wptr_q;
                M_HWRITE = 1'b1;
                M_HSIZE  = SZ_HALF;
            end
            ARM_D:   M_HWDATA = 32'h0000_000A;
            CLR_D:   M_HWDATA = 32'h0000_000B;
            WR_D:    M_HWDATA = {20'b0, pixel_q};
            default: ;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign line_cnt = line_q;
endmodule
